pc_stack: RTL and testbench
===========================

Name: pc_stack

Overview:
- Parametrised program counter with an integrated hardware return-address stack.
- Next generation of the single-bit load register: a W-bit register with several update modes (hold, increment, load, call, return).
- Sits between the CPU control decode and the instruction memory address port.
- Registered outputs; all updates on the rising clock edge.

Parameters:
WIDTH, 16, bit width of the PC, the address input and each stack entry
DEPTH, 8, number of return-address stack entries (>=2)
RESET_VEC, 0, value loaded into the PC on reset

Ports:
clk_i  input  1  system clock, rising edge active
rst_n_i  input  1  synchronous active-low reset
inc_i  input  1  PC <= PC+1
load_i  input  1  PC <= addr_i
call_i  input  1  push PC+1 onto stack, PC <= addr_i
ret_i  input  1  PC <= top of stack, pop
clr_err_i  input  1  clear sticky error flags
addr_i  input  WIDTH  jump/call target
pc_o  output  WIDTH  current program counter
depth_o  output  $clog2(DEPTH+1)  number of valid stack entries
empty_o  output  1  depth_o == 0
full_o  output  1  depth_o == DEPTH
ovf_o  output  1  sticky: call attempted while full
unf_o  output  1  sticky: return attempted while empty

Behaviour:
- One clock domain. Reset is synchronous, active-low, sampled on the rising edge of clk_i and takes priority over all other inputs.
- Reset values:
  - pc_o = RESET_VEC, depth_o = 0, empty_o = 1, full_o = 0, ovf_o = 0, unf_o = 0.
  - Stack RAM contents are not reset and are never observable while empty.
- Op priority per edge: ret_i > call_i > load_i > inc_i > hold. Only the winning op takes effect; the other asserted ops in that cycle are ignored entirely.
- Latency: every op result is visible on pc_o and the flags one cycle after the edge that samples it. No combinational input-to-output paths.
- Arithmetic: PC+1 is computed modulo 2^WIDTH. PC = all-ones with inc_i gives 0. A call at all-ones pushes 0.
- CALL, not full:
  - stack[depth] <= pc_o+1, depth++, pc_o <= addr_i.
- CALL, full:
  - pc_o <= addr_i, stack and depth unchanged, ovf_o <= 1.
- RET, not empty:
  - pc_o <= stack[depth-1], depth--.
- RET, empty:
  - pc_o holds, depth stays 0, unf_o <= 1.
- LOAD: pc_o <= addr_i. INC: pc_o <= pc_o+1. HOLD: no change.
- Stack ordering is LIFO; depth_o moves by at most ±1 per cycle.
- Error flags:
  - ovf_o/unf_o stay set until reset or clr_err_i.
  - If clr_err_i coincides with a new error event, the flag is set (the set wins).
- Reset asserted mid-sequence (e.g. with the stack part-filled) discards all entries; the next ret_i is an underflow.

Decomposition:
- Package pc_stack_pkg:
  - op_e enum {OP_HOLD, OP_INC, OP_LOAD, OP_CALL, OP_RET}.
  - Priority-decode function mapping (ret, call, load, inc) to op_e.
  - Localparam DW = $clog2(DEPTH+1).
- Sub-module lifo_stack (WIDTH, DEPTH):
  - Inputs: push, pop, wdata. Outputs: rdata (top), depth, empty, full.
  - Ignores push when full and pop when empty.
- pc_stack top: PC register, op decode and error flags.

Test Plan:
- Reset then inc_i for 3 cycles -> pc_o 0,1,2,3. Reset with RESET_VEC=0x0100 -> pc_o=0x0100 one cycle after the reset edge.
- pc_o=0x0010, call_i addr_i=0x0200 -> pc_o=0x0200, depth_o=1. Then ret_i -> pc_o=0x0011, depth_o=0, empty_o=1.
- Nested calls from 0x0005: first call to 0x0100, then from 0x0100 call to 0x0200, then two ret_i -> pc_o 0x0101, then 0x0006.
- DEPTH=8: 9 calls -> full_o=1 after the 8th. The 9th sets ovf_o=1 with pc_o=its addr_i and depth_o=8. clr_err_i -> ovf_o=0.
- ret_i while empty with pc_o=0x0042 -> pc_o stays 0x0042, unf_o=1. Then ret_i+call_i+load_i together with depth 1 -> only the pop occurs.
- pc_o=0xFFFF with inc_i -> 0x0000. Fill 3 entries, pulse rst_n_i low for one edge -> depth_o=0, pc_o=RESET_VEC. Next ret_i -> unf_o=1.

Source files
------------

// File: rtl/pc_stack_pkg.sv
// Shared types and helpers for the program counter with return-address stack.
// Op encoding, priority decode and the default depth-counter width.
package pc_stack_pkg;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_INC,
        OP_LOAD,
        OP_CALL,
        OP_RET
    } op_e;

    localparam int unsigned DEPTH_DEFAULT = 8;
    localparam int unsigned DW            = $clog2(DEPTH_DEFAULT + 1);

    // Only the highest-priority request wins; lower ones are dropped entirely.
    function automatic op_e decode_op(input logic ret, input logic call,
                                      input logic load, input logic inc);
        if (ret)       return OP_RET;
        else if (call) return OP_CALL;
        else if (load) return OP_LOAD;
        else if (inc)  return OP_INC;
        else           return OP_HOLD;
    endfunction

endpackage

// File: rtl/lifo_stack.sv
// Return-address LIFO: fill-count register plus non-reset storage.
// Pushes while full and pops while empty are silently ignored.
module lifo_stack #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [WIDTH-1:0]             wdata_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]   depth_o,
    output logic                         empty_o,
    output logic                         full_o
);

    localparam int unsigned DEPTH_W = $clog2(DEPTH + 1);
    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [DEPTH_W-1:0] top_idx;

    assign empty_o = (depth_q == '0);
    assign full_o  = (depth_q == DEPTH_W'(DEPTH));
    assign depth_o = depth_q;

    // Read data is meaningless when empty; the caller never consumes it then.
    assign top_idx = depth_q - DEPTH_W'(1);
    assign rdata_o = mem_q[top_idx[AW-1:0]];

    always_comb begin
        mem_d   = mem_q;
        depth_d = depth_q;
        if (push_i && !full_o) begin
            mem_d[depth_q[AW-1:0]] = wdata_i;
            depth_d                = depth_q + DEPTH_W'(1);
        end else if (pop_i && !empty_o) begin
            depth_d = depth_q - DEPTH_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pc_stack.sv
// Program counter with hold/inc/load/call/return and sticky stack error flags.
// All outputs come straight from registers; ops resolve by fixed priority.
module pc_stack
    import pc_stack_pkg::*;
#(
    parameter int unsigned     WIDTH     = 16,
    parameter int unsigned     DEPTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       inc_i,
    input  logic                       load_i,
    input  logic                       call_i,
    input  logic                       ret_i,
    input  logic                       clr_err_i,
    input  logic [WIDTH-1:0]           addr_i,
    output logic [WIDTH-1:0]           pc_o,
    output logic [$clog2(DEPTH+1)-1:0] depth_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic                       ovf_o,
    output logic                       unf_o
);

    op_e              op;
    logic [WIDTH-1:0] pc_q, pc_d, pc_inc, stk_top;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             push, pop, stk_empty, stk_full;

    lifo_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lifo_stack (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (pc_inc),
        .rdata_o (stk_top),
        .depth_o (depth_o),
        .empty_o (stk_empty),
        .full_o  (stk_full)
    );

    always_comb begin
        op     = decode_op(ret_i, call_i, load_i, inc_i);
        pc_inc = pc_q + WIDTH'(1);
        pc_d   = pc_q;
        push   = 1'b0;
        pop    = 1'b0;
        // A new error event in the same cycle as a clear leaves the flag set.
        ovf_d  = ovf_q & ~clr_err_i;
        unf_d  = unf_q & ~clr_err_i;
        unique case (op)
            OP_RET: begin
                if (stk_empty) begin
                    unf_d = 1'b1;
                end else begin
                    pc_d = stk_top;
                    pop  = 1'b1;
                end
            end
            OP_CALL: begin
                pc_d = addr_i;
                if (stk_full) begin
                    ovf_d = 1'b1;
                end else begin
                    push = 1'b1;
                end
            end
            OP_LOAD: pc_d = addr_i;
            OP_INC:  pc_d = pc_inc;
            OP_HOLD: pc_d = pc_q;
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pc_q  <= RESET_VEC;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign pc_o    = pc_q;
    assign empty_o = stk_empty;
    assign full_o  = stk_full;
    assign ovf_o   = ovf_q;
    assign unf_o   = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// Scoreboard bench for pc_stack: each applied op queues its expected state,
// which is popped and compared one cycle later. A second instance checks RESET_VEC.
module tb_pc_stack;

    logic        clk = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        inc_i = 1'b0, load_i = 1'b0, call_i = 1'b0, ret_i = 1'b0, clr_err_i = 1'b0;
    logic [15:0] addr_i = '0;
    logic [15:0] pc_o, pc2_o;
    logic [3:0]  depth_o, depth2_o;
    logic        empty_o, full_o, ovf_o, unf_o;
    logic        empty2_o, full2_o, ovf2_o, unf2_o;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        rst, r, c, l, i, clr;
        logic [15:0] addr;
        logic [15:0] pc;
        logic [3:0]  d;
        logic        ovf, unf;
    } stim_t;

    typedef struct {
        logic [15:0] pc;
        logic [3:0]  d;
        logic        ovf, unf;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pc_stack dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .inc_i(inc_i), .load_i(load_i), .call_i(call_i),
        .ret_i(ret_i), .clr_err_i(clr_err_i), .addr_i(addr_i), .pc_o(pc_o),
        .depth_o(depth_o), .empty_o(empty_o), .full_o(full_o), .ovf_o(ovf_o), .unf_o(unf_o)
    );

    pc_stack #(.WIDTH(16), .DEPTH(8), .RESET_VEC(16'h0100)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n_i), .inc_i(inc_i), .load_i(load_i), .call_i(call_i),
        .ret_i(ret_i), .clr_err_i(clr_err_i), .addr_i(addr_i), .pc_o(pc2_o),
        .depth_o(depth2_o), .empty_o(empty2_o), .full_o(full2_o), .ovf_o(ovf2_o),
        .unf_o(unf2_o)
    );

    // Argument order: rst, ret, call, load, inc, clr, addr | expected pc, depth, ovf, unf
    function automatic stim_t s(input logic rst, input logic r, input logic c, input logic l,
                                input logic i, input logic clr, input logic [15:0] addr,
                                input logic [15:0] pc, input logic [3:0] d,
                                input logic ovf, input logic unf);
        stim_t v;
        v.rst = rst; v.r = r; v.c = c; v.l = l; v.i = i; v.clr = clr; v.addr = addr;
        v.pc = pc; v.d = d; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic apply(input stim_t v);
        exp_t e;
        rst_n_i = ~v.rst; ret_i = v.r; call_i = v.c; load_i = v.l; inc_i = v.i;
        clr_err_i = v.clr; addr_i = v.addr;
        e.pc = v.pc; e.d = v.d; e.ovf = v.ovf; e.unf = v.unf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        rst_n_i = 1'b1; ret_i = 1'b0; call_i = 1'b0; load_i = 1'b0; inc_i = 1'b0;
        clr_err_i = 1'b0;
    endtask

    task automatic test_reset();
        stim_t v[$];
        exp_t  e;
        v.push_back(s(1, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0));
        for (int k = 1; k <= 3; k++) v.push_back(s(0, 0, 0, 0, 1, 0, 0, 16'(k), 0, 0, 0));
        foreach (v[k]) begin
            apply(v[k]);
            e = sb.pop_front();
            n_cmp++;
            if ({pc_o, depth_o, empty_o, full_o, ovf_o, unf_o} !==
                {e.pc, e.d, e.d == 4'd0, e.d == 4'd8, e.ovf, e.unf}) begin
                n_err++;
                $display("FAIL reset[%0d]: got pc=%h d=%0d e=%b f=%b ovf=%b unf=%b, exp pc=%h d=%0d ovf=%b unf=%b",
                         k, pc_o, depth_o, empty_o, full_o, ovf_o, unf_o, e.pc, e.d, e.ovf, e.unf);
            end
            if (k == 0 || k == 3) begin
                n_cmp++;
                if (pc2_o !== 16'h0100 + 16'(k)) begin
                    n_err++;
                    $display("FAIL reset_vec[%0d]: got pc=%h exp %h", k, pc2_o, 16'h0100 + 16'(k));
                end
            end
        end
    endtask

    task automatic test_call_ret();
        stim_t v[$];
        exp_t  e;
        v.push_back(s(0, 0, 0, 1, 0, 0, 16'h0010, 16'h0010, 0, 0, 0));
        v.push_back(s(0, 0, 1, 0, 0, 0, 16'h0200, 16'h0200, 1, 0, 0));
        v.push_back(s(0, 1, 0, 0, 0, 0, 16'h0000, 16'h0011, 0, 0, 0));
        foreach (v[k]) begin
            apply(v[k]);
            e = sb.pop_front();
            n_cmp++;
            if ({pc_o, depth_o, empty_o, full_o, ovf_o, unf_o} !==
                {e.pc, e.d, e.d == 4'd0, e.d == 4'd8, e.ovf, e.unf}) begin
                n_err++;
                $display("FAIL call_ret[%0d]: got pc=%h d=%0d e=%b f=%b ovf=%b unf=%b, exp pc=%h d=%0d ovf=%b unf=%b",
                         k, pc_o, depth_o, empty_o, full_o, ovf_o, unf_o, e.pc, e.d, e.ovf, e.unf);
            end
        end
    endtask

    task automatic test_nested();
        stim_t v[$];
        exp_t  e;
        v.push_back(s(0, 0, 0, 1, 0, 0, 16'h0005, 16'h0005, 0, 0, 0));
        v.push_back(s(0, 0, 1, 0, 0, 0, 16'h0100, 16'h0100, 1, 0, 0));
        v.push_back(s(0, 0, 1, 0, 0, 0, 16'h0200, 16'h0200, 2, 0, 0));
        v.push_back(s(0, 1, 0, 0, 0, 0, 16'h0000, 16'h0101, 1, 0, 0));
        v.push_back(s(0, 1, 0, 0, 0, 0, 16'h0000, 16'h0006, 0, 0, 0));
        foreach (v[k]) begin
            apply(v[k]);
            e = sb.pop_front();
            n_cmp++;
            if ({pc_o, depth_o, empty_o, full_o, ovf_o, unf_o} !==
                {e.pc, e.d, e.d == 4'd0, e.d == 4'd8, e.ovf, e.unf}) begin
                n_err++;
                $display("FAIL nested[%0d]: got pc=%h d=%0d e=%b f=%b ovf=%b unf=%b, exp pc=%h d=%0d ovf=%b unf=%b",
                         k, pc_o, depth_o, empty_o, full_o, ovf_o, unf_o, e.pc, e.d, e.ovf, e.unf);
            end
        end
    endtask

    task automatic test_overflow();
        stim_t v[$];
        exp_t  e;
        // From pc=0x0006: nine calls; the ninth hits a full stack.
        for (int k = 0; k < 9; k++)
            v.push_back(s(0, 0, 1, 0, 0, 0, 16'h1000 + 16'(k), 16'h1000 + 16'(k),
                          (k < 8) ? 4'(k + 1) : 4'd8, k == 8, 0));
        v.push_back(s(0, 0, 0, 0, 0, 1, 16'h0000, 16'h1008, 8, 0, 0));
        v.push_back(s(0, 1, 0, 0, 1, 0, 16'h0000, 16'h1007, 7, 0, 0));
        v.push_back(s(0, 1, 0, 0, 0, 0, 16'h0000, 16'h1006, 6, 0, 0));
        v.push_back(s(0, 0, 1, 0, 0, 0, 16'h2000, 16'h2000, 7, 0, 0));
        v.push_back(s(0, 0, 1, 0, 0, 0, 16'h2001, 16'h2001, 8, 0, 0));
        v.push_back(s(0, 0, 1, 0, 0, 1, 16'h2002, 16'h2002, 8, 1, 0));
        foreach (v[k]) begin
            apply(v[k]);
            e = sb.pop_front();
            n_cmp++;
            if ({pc_o, depth_o, empty_o, full_o, ovf_o, unf_o} !==
                {e.pc, e.d, e.d == 4'd0, e.d == 4'd8, e.ovf, e.unf}) begin
                n_err++;
                $display("FAIL overflow[%0d]: got pc=%h d=%0d e=%b f=%b ovf=%b unf=%b, exp pc=%h d=%0d ovf=%b unf=%b",
                         k, pc_o, depth_o, empty_o, full_o, ovf_o, unf_o, e.pc, e.d, e.ovf, e.unf);
            end
        end
    endtask

    task automatic test_underflow();
        stim_t v[$];
        exp_t  e;
        v.push_back(s(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
        v.push_back(s(0, 0, 0, 1, 0, 0, 16'h0042, 16'h0042, 0, 0, 0));
        v.push_back(s(0, 1, 0, 0, 0, 0, 16'h0000, 16'h0042, 0, 0, 1));
        v.push_back(s(0, 1, 0, 0, 0, 1, 16'h0000, 16'h0042, 0, 0, 1));
        v.push_back(s(0, 0, 0, 0, 0, 1, 16'h0000, 16'h0042, 0, 0, 0));
        v.push_back(s(0, 0, 1, 0, 0, 0, 16'h0300, 16'h0300, 1, 0, 0));
        v.push_back(s(0, 1, 1, 1, 1, 0, 16'h0999, 16'h0043, 0, 0, 0));
        foreach (v[k]) begin
            apply(v[k]);
            e = sb.pop_front();
            n_cmp++;
            if ({pc_o, depth_o, empty_o, full_o, ovf_o, unf_o} !==
                {e.pc, e.d, e.d == 4'd0, e.d == 4'd8, e.ovf, e.unf}) begin
                n_err++;
                $display("FAIL underflow[%0d]: got pc=%h d=%0d e=%b f=%b ovf=%b unf=%b, exp pc=%h d=%0d ovf=%b unf=%b",
                         k, pc_o, depth_o, empty_o, full_o, ovf_o, unf_o, e.pc, e.d, e.ovf, e.unf);
            end
        end
    endtask

    task automatic test_wrap();
        stim_t v[$];
        exp_t  e;
        v.push_back(s(0, 0, 0, 1, 0, 0, 16'hFFFF, 16'hFFFF, 0, 0, 0));
        v.push_back(s(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0));
        v.push_back(s(0, 0, 0, 1, 0, 0, 16'hFFFF, 16'hFFFF, 0, 0, 0));
        v.push_back(s(0, 0, 1, 0, 0, 0, 16'h0010, 16'h0010, 1, 0, 0));
        v.push_back(s(0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
        foreach (v[k]) begin
            apply(v[k]);
            e = sb.pop_front();
            n_cmp++;
            if ({pc_o, depth_o, empty_o, full_o, ovf_o, unf_o} !==
                {e.pc, e.d, e.d == 4'd0, e.d == 4'd8, e.ovf, e.unf}) begin
                n_err++;
                $display("FAIL wrap[%0d]: got pc=%h d=%0d e=%b f=%b ovf=%b unf=%b, exp pc=%h d=%0d ovf=%b unf=%b",
                         k, pc_o, depth_o, empty_o, full_o, ovf_o, unf_o, e.pc, e.d, e.ovf, e.unf);
            end
        end
    endtask

    task automatic test_reset_mid();
        stim_t v[$];
        exp_t  e;
        v.push_back(s(0, 0, 1, 0, 0, 0, 16'h0020, 16'h0020, 1, 0, 0));
        v.push_back(s(0, 0, 1, 0, 0, 0, 16'h0030, 16'h0030, 2, 0, 0));
        v.push_back(s(0, 0, 1, 0, 0, 0, 16'h0040, 16'h0040, 3, 0, 0));
        v.push_back(s(0, 0, 1, 0, 0, 0, 16'h0050, 16'h0050, 4, 0, 0));
        v.push_back(s(1, 0, 1, 0, 1, 0, 16'h0060, 16'h0000, 0, 0, 0));
        v.push_back(s(0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1));
        foreach (v[k]) begin
            apply(v[k]);
            e = sb.pop_front();
            n_cmp++;
            if ({pc_o, depth_o, empty_o, full_o, ovf_o, unf_o} !==
                {e.pc, e.d, e.d == 4'd0, e.d == 4'd8, e.ovf, e.unf}) begin
                n_err++;
                $display("FAIL reset_mid[%0d]: got pc=%h d=%0d e=%b f=%b ovf=%b unf=%b, exp pc=%h d=%0d ovf=%b unf=%b",
                         k, pc_o, depth_o, empty_o, full_o, ovf_o, unf_o, e.pc, e.d, e.ovf, e.unf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_call_ret();
        test_nested();
        test_overflow();
        test_underflow();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
